// File: rtl/gbt_tx_frameclk_phalgnr_pkg.sv
// Shared types and default constants for the GBT TX frame-clock phase aligner
// dynamic-phase-shift (DPS) controller.
package gbt_tx_frameclk_phalgnr_pkg;

  localparam int unsigned STEPS_PER_CYCLE_DEF = 144;
  localparam int unsigned TIMEOUT_DEF         = 255;

  typedef enum logic [2:0] {
    IDLE,
    CALC,
    EN,
    WAIT_LO,
    WAIT_HI,
    NEXT
  } state_t;

endpackage

// File: rtl/gbt_tx_frameclk_phalgnr_sync.sv
// Two-flop synchronizer for a single asynchronous level, with the reset value
// chosen per instance so the synced level idles at its inactive state.
module gbt_tx_frameclk_phalgnr_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its neighbour, which is what makes this a 2-stage chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/gbt_tx_frameclk_phalgnr_dps_ctrl.sv
// Steps the PLL frame-clock counter phase one DPS step at a time, taking the
// shortest way round the frame-clock period to reach the requested position.
module gbt_tx_frameclk_phalgnr_dps_ctrl
  import gbt_tx_frameclk_phalgnr_pkg::*;
#(
  parameter int unsigned STEPS_PER_CYCLE = STEPS_PER_CYCLE_DEF,
  parameter int unsigned TIMEOUT         = TIMEOUT_DEF,
  parameter logic [4:0]  CNTSEL_VAL      = 5'd0
) (
  input  logic       scanclk,
  input  logic       rst_n,
  input  logic       locked,
  input  logic       start,
  input  logic [7:0] target_phase,
  input  logic       phase_done,
  output logic       phase_en,
  output logic       updn,
  output logic [4:0] cntsel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] cur_phase
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 2);
  localparam logic [8:0]  STEPS9 = 9'(STEPS_PER_CYCLE);
  localparam logic [8:0]  HALF9  = 9'(STEPS_PER_CYCLE / 2);
  localparam logic [7:0]  LAST   = 8'(STEPS_PER_CYCLE - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

  logic locked_s;
  logic pd_s;

  gbt_tx_frameclk_phalgnr_sync #(.RST_VAL(1'b0)) u_sync_locked (
    .clk   (scanclk),
    .rst_n (rst_n),
    .d     (locked),
    .q     (locked_s)
  );

  gbt_tx_frameclk_phalgnr_sync #(.RST_VAL(1'b1)) u_sync_phase_done (
    .clk   (scanclk),
    .rst_n (rst_n),
    .d     (phase_done),
    .q     (pd_s)
  );

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             en_q, en_d;
  logic             updn_q, updn_d;
  logic [7:0]       cur_q, cur_d;
  logic [7:0]       tgt_q, tgt_d;
  logic [7:0]       rem_q, rem_d;
  logic [1:0]       en_cnt_q, en_cnt_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [8:0] tgt9, cur9, diff9;
  logic       go_up;

  // Shortest signed distance round the period, kept in 9 bits so the
  // wrap-around sum never overflows.
  always_comb begin
    tgt9  = {1'b0, tgt_q};
    cur9  = {1'b0, cur_q};
    diff9 = (tgt9 >= cur9) ? (tgt9 - cur9) : (tgt9 + STEPS9 - cur9);
    go_up = (diff9 <= HALF9);
  end

  always_comb begin
    // NOTE: every variable gets its default first, so no path leaves one
    // unassigned and no latch is inferred.
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    en_d     = 1'b0;
    updn_d   = updn_q;
    cur_d    = cur_q;
    tgt_d    = tgt_q;
    rem_d    = rem_q;
    en_cnt_d = en_cnt_q;
    tmo_d    = tmo_q;

    if (!locked_s) begin
      // Loss of lock invalidates the tracked phase; abort whatever was running.
      state_d  = IDLE;
      busy_d   = 1'b0;
      cur_d    = '0;
      rem_d    = '0;
      en_cnt_d = '0;
      tmo_d    = '0;
      if (busy_q) error_d = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = CALC;
            busy_d  = 1'b1;
            error_d = 1'b0;
            tgt_d   = target_phase;
          end
        end
        CALC: begin
          if (tgt9 >= STEPS9) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else if (diff9 == 9'd0) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d  = EN;
            updn_d   = go_up;
            rem_d    = go_up ? diff9[7:0] : 8'(STEPS9 - diff9);
            en_cnt_d = '0;
          end
        end
        EN: begin
          // First EN cycle gives updn a cycle of setup before phase_en rises.
          en_d     = 1'b1;
          en_cnt_d = en_cnt_q + 2'd1;
          if (en_cnt_q == 2'd2) begin
            en_d     = 1'b0;
            en_cnt_d = '0;
            tmo_d    = '0;
            state_d  = WAIT_LO;
          end
        end
        WAIT_LO, WAIT_HI: begin
          if (state_q == WAIT_LO && !pd_s) begin
            state_d = WAIT_HI;
            tmo_d   = tmo_q + 1'b1;
          end else if (state_q == WAIT_HI && pd_s) begin
            state_d = NEXT;
            rem_d   = rem_q - 8'd1;
            if (updn_q) cur_d = (cur_q == LAST) ? 8'd0 : cur_q + 8'd1;
            else        cur_d = (cur_q == 8'd0) ? LAST : cur_q - 8'd1;
          end else if (tmo_q >= TMO_MAX) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            error_d = 1'b1;
          end else begin
            tmo_d = tmo_q + 1'b1;
          end
        end
        NEXT: begin
          if (rem_q != 8'd0) begin
            state_d  = EN;
            en_cnt_d = '0;
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge scanclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      en_q     <= 1'b0;
      updn_q   <= 1'b0;
      cur_q    <= '0;
      tgt_q    <= '0;
      rem_q    <= '0;
      en_cnt_q <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      en_q     <= en_d;
      updn_q   <= updn_d;
      cur_q    <= cur_d;
      tgt_q    <= tgt_d;
      rem_q    <= rem_d;
      en_cnt_q <= en_cnt_d;
      tmo_q    <= tmo_d;
    end
  end

  assign phase_en  = en_q;
  assign updn      = updn_q;
  assign cntsel    = CNTSEL_VAL;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign cur_phase = cur_q;

endmodule

// File: tb/tb_gbt_tx_frameclk_phalgnr_dps_ctrl.sv
// Self-checking bench: a PLL DPS responder, a per-cycle protocol monitor and
// a transaction-level phase model for the frame-clock DPS controller.
module tb_gbt_tx_frameclk_phalgnr_dps_ctrl;

  localparam int         STEPS   = 144;
  localparam int         TIMEOUT = 255;
  localparam logic [4:0] CNTSEL  = 5'd0;

  logic       scanclk = 1'b0;
  logic       rst_n;
  logic       locked;
  logic       start;
  logic [7:0] target_phase;
  logic       phase_done;
  logic       phase_en;
  logic       updn;
  logic [4:0] cntsel;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] cur_phase;

  gbt_tx_frameclk_phalgnr_dps_ctrl #(
    .STEPS_PER_CYCLE (STEPS),
    .TIMEOUT         (TIMEOUT),
    .CNTSEL_VAL      (CNTSEL)
  ) dut (
    .scanclk      (scanclk),
    .rst_n        (rst_n),
    .locked       (locked),
    .start        (start),
    .target_phase (target_phase),
    .phase_done   (phase_done),
    .phase_en     (phase_en),
    .updn         (updn),
    .cntsel       (cntsel),
    .busy         (busy),
    .done         (done),
    .error        (error),
    .cur_phase    (cur_phase)
  );

  always #5 scanclk = ~scanclk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int fall_cyc = 0;
  int n_rise = 0;
  int n_done = 0;
  int en_w = 0;
  int model_phase = 0;
  bit exp_dir = 1'b1;
  bit pll_stuck = 1'b0;
  bit lock_drop = 1'b0;
  bit saw_wrap = 1'b0;
  logic prev_en = 1'b0;
  logic prev_updn = 1'b0;
  logic [7:0] prev_cur = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic int step_of(input int p, input bit up);
    return up ? (p + 1) % STEPS : (p + STEPS - 1) % STEPS;
  endfunction

  // PLL DPS responder: after each phase_en pulse, phase_done drops for a few
  // cycles and returns high, unless the PLL is modelled as stuck.
  initial begin
    phase_done = 1'b1;
    forever begin
      do begin @(posedge scanclk); #1; end while (phase_en !== 1'b1);
      do begin @(posedge scanclk); #1; end while (phase_en !== 1'b0);
      if (!pll_stuck) begin
        repeat ($urandom_range(0, 3)) @(posedge scanclk);
        #1 phase_done = 1'b0;
        repeat ($urandom_range(1, 4)) @(posedge scanclk);
        #1 phase_done = 1'b1;
      end
    end
  end

  // Per-cycle protocol monitor.
  always @(negedge scanclk) begin
    cyc++;
    check("cntsel", cntsel, CNTSEL);
    if (rst_n) begin
      if (phase_en) begin
        check("en_needs_busy", busy, 1);
        check("updn_dir", updn, exp_dir);
      end
      if (phase_en && !prev_en) begin
        n_rise++;
        check("updn_setup", updn, prev_updn);
      end
      if (!phase_en && prev_en) begin
        check("en_width", en_w, 2);
        fall_cyc = cyc;
      end
      if (done) begin
        n_done++;
        check("done_no_error", error, 0);
      end
      if (cur_phase != prev_cur && !lock_drop)
        check("cur_step", cur_phase, step_of(prev_cur, exp_dir));
      if (cur_phase == 8'(STEPS - 1)) saw_wrap = 1'b1;
    end
    en_w      = phase_en ? en_w + 1 : 0;
    prev_en   = phase_en;
    prev_updn = updn;
    prev_cur  = cur_phase;
  end

  task automatic issue_start(input int tgt, input bit up);
    @(posedge scanclk); #1;
    start = 1'b1;
    target_phase = 8'(tgt);
    exp_dir = up;
    n_rise = 0;
    n_done = 0;
    @(posedge scanclk); #1;
    start = 1'b0;
    @(negedge scanclk); #1;
    check("busy_after_accept", busy, 1);
    check("error_cleared", error, 0);
  endtask

  task automatic run_txn(input int tgt, input bit glitch);
    int d, n_exp, fin, waited, budget;
    bit up, bad;
    bad    = (tgt >= STEPS);
    d      = bad ? 0 : (tgt - model_phase + STEPS) % STEPS;
    up     = (d <= STEPS / 2);
    n_exp  = bad ? 0 : (up ? d : STEPS - d);
    fin    = bad ? model_phase : tgt;
    budget = 40 * n_exp + 20;
    issue_start(tgt, up);
    waited = 0;
    while (!(done || error) && waited < budget) begin
      if (glitch && waited == 6) begin
        start = 1'b1;
        target_phase = 8'($urandom_range(0, STEPS - 1));
      end else begin
        start = 1'b0;
      end
      @(negedge scanclk); #1;
      waited++;
    end
    start = 1'b0;
    if (!(done || error)) begin
      n_vec++;
      n_err++;
      $display("FAIL txn_end tgt=%0d: no done or error within %0d cycles", tgt, budget);
    end
    if (n_exp == 0) check("zero_latency", waited, 1);
    check("txn_error", error, bad);
    check("busy_end", busy, 0);
    @(negedge scanclk); #1;
    check("done_pulses", n_done, bad ? 0 : 1);
    check("step_count", n_rise, n_exp);
    check("final_phase", cur_phase, fin);
    model_phase = fin;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int tgt, waited;
    rst_n = 1'b0;
    locked = 1'b0;
    start = 1'b0;
    target_phase = '0;

    // Reset state.
    repeat (3) @(negedge scanclk);
    #1;
    check("rst_phase_en", phase_en, 0);
    check("rst_updn", updn, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_cur_phase", cur_phase, 0);
    @(posedge scanclk); #1;
    rst_n = 1'b1;

    // No activity before lock.
    n_rise = 0;
    @(posedge scanclk); #1;
    start = 1'b1;
    target_phase = 8'd10;
    @(posedge scanclk); #1;
    start = 1'b0;
    repeat (4) @(negedge scanclk);
    #1;
    check("prelock_busy", busy, 0);
    check("prelock_steps", n_rise, 0);
    locked = 1'b1;
    repeat (5) @(negedge scanclk);

    // Hand-computed expectations pinning the model.
    run_txn(10, 1'b0);
    check("t10_updn", updn, 1);
    check("t10_phase", cur_phase, 10);
    saw_wrap = 1'b0;
    run_txn(140, 1'b0);
    check("t140_steps", n_rise, 14);
    check("t140_updn", updn, 0);
    check("t140_wrap", saw_wrap, 1);
    check("t140_phase", cur_phase, 140);
    run_txn(140, 1'b0);
    check("same_steps", n_rise, 0);
    run_txn(144, 1'b0);
    check("bad_error", error, 1);
    run_txn((model_phase + 72) % STEPS, 1'b0);
    check("half_steps", n_rise, 72);
    check("half_updn", updn, 1);
    run_txn((model_phase + 73) % STEPS, 1'b1);
    check("half1_steps", n_rise, 71);
    check("half1_updn", updn, 0);

    // PLL never drops phase_done: timeout after TIMEOUT+1 cycles.
    pll_stuck = 1'b1;
    tgt = (model_phase + 5) % STEPS;
    issue_start(tgt, 1'b1);
    waited = 0;
    while (!error && waited < TIMEOUT + 60) begin
      @(negedge scanclk); #1;
      waited++;
    end
    check("tmo_latency", cyc - fall_cyc, TIMEOUT + 1);
    check("tmo_error", error, 1);
    check("tmo_busy", busy, 0);
    check("tmo_steps", n_rise, 1);
    check("tmo_phase", cur_phase, model_phase);
    pll_stuck = 1'b0;
    repeat (3) @(negedge scanclk);

    // Lock lost while waiting for phase_done to fall.
    pll_stuck = 1'b1;
    tgt = (model_phase + 30) % STEPS;
    issue_start(tgt, 1'b1);
    waited = 0;
    while (!(n_rise >= 1 && !phase_en) && waited < 30) begin
      @(negedge scanclk); #1;
      waited++;
    end
    check("lock_first_step", n_rise, 1);
    lock_drop = 1'b1;
    locked = 1'b0;
    waited = 0;
    while (busy && waited < 10) begin
      @(negedge scanclk); #1;
      waited++;
    end
    check("lock_phase_en", phase_en, 0);
    check("lock_cur_phase", cur_phase, 0);
    check("lock_error", error, 1);
    check("lock_busy", busy, 0);
    pll_stuck = 1'b0;
    locked = 1'b1;
    repeat (6) @(negedge scanclk);
    #1;
    lock_drop = 1'b0;
    model_phase = 0;

    // Randomized transactions.
    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(0, 9) == 0) tgt = $urandom_range(STEPS, 255);
      else                           tgt = $urandom_range(0, STEPS - 1);
      run_txn(tgt, 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/gbt_tx_frameclk_phalgnr_dps_ctrl.md
GBT_TX_FRAMECLK_PHALGNR_DPS_CTRL -- requirements
Module: gbt_tx_frameclk_phalgnr_dps_ctrl

Interface
REQ-001 Parameter STEPS_PER_CYCLE, default 144, meaning DPS steps per 40 MHz frame-clock period (720 MHz VCO, 1/8 VCO step).
REQ-002 Parameter TIMEOUT, default 255, meaning the maximum scanclk cycles allowed per step for phase_done completion.
REQ-003 Parameter CNTSEL_VAL, default 5'd0, meaning the PLL counter selected for shifting (C0, frame clock).
REQ-004 scanclk  in  1  the single clock, also driven to the PLL DPS scanclk.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 locked  in  1  PLL lock indication, treated as asynchronous.
REQ-007 start  in  1  request pulse, accepted only in IDLE.
REQ-008 target_phase  in  8  requested phase position, 0..STEPS_PER_CYCLE-1.
REQ-009 phase_done  in  1  PLL DPS completion, asynchronous, idles high.
REQ-010 phase_en  out  1  PLL DPS step enable.
REQ-011 updn  out  1  step direction, 1 = up (advance), 0 = down.
REQ-012 cntsel  out  5  counter select, constant CNTSEL_VAL.
REQ-013 busy  out  1  high from accept until done or error.
REQ-014 done  out  1  one-cycle pulse on successful completion.
REQ-015 error  out  1  sticky fault flag, cleared on next accepted start.
REQ-016 cur_phase  out  8  current tracked phase position.

Function
REQ-017 locked and phase_done SHALL pass through 2-flop synchronizers before use; phase_done sync flops reset to 1, locked sync flops reset to 0.
REQ-018 FSM states SHALL be IDLE, CALC, EN, WAIT_LO, WAIT_HI, NEXT, with exit to IDLE setting done or error.
REQ-019 IDLE: start=1 and synced locked=1 SHALL accept in cycle N, busy=1 from N+1, error cleared; start in any other state SHALL be ignored.
REQ-020 CALC (N+1): target_phase >= STEPS_PER_CYCLE SHALL set error and return to IDLE with no phase_en activity.
REQ-021 CALC: diff = (target - cur_phase) mod STEPS_PER_CYCLE; diff=0 -> done pulse at N+2; diff <= STEPS_PER_CYCLE/2 -> diff up-steps; else STEPS_PER_CYCLE-diff down-steps (diff=72 goes up).
REQ-022 EN: phase_en=1 for exactly 2 cycles; updn and cntsel SHALL be stable from one cycle before phase_en rises until synced phase_done returns high.
REQ-023 WAIT_LO waits synced phase_done=0, then WAIT_HI waits synced phase_done=1; a per-step counter from phase_en fall exceeding TIMEOUT SHALL set error and return to IDLE.
REQ-024 On WAIT_HI completion cur_phase SHALL update by one step, wrapping STEPS_PER_CYCLE-1 -> 0 (up) and 0 -> STEPS_PER_CYCLE-1 (down).
REQ-025 NEXT: remaining steps > 0 -> EN next cycle; else done=1 for one cycle, busy=0, IDLE.
REQ-026 Synced locked falling in any state SHALL force phase_en=0, cur_phase=0, IDLE; error=1 if busy at the time.
REQ-027 Remaining-step counter SHALL be 8-bit unsigned; mod arithmetic SHALL be computed in 9 bits without overflow.

Reset
REQ-028 rst_n low SHALL asynchronously force IDLE, phase_en=0, updn=0, busy=0, done=0, error=0, cur_phase=0, counters=0; cntsel SHALL equal CNTSEL_VAL at all times.
REQ-029 Reset release SHALL be synchronous to scanclk via the existing reset-release convention; no DPS activity before synced locked=1.

Structure
REQ-030 Package gbt_tx_frameclk_phalgnr_pkg SHALL hold the FSM state type, STEPS_PER_CYCLE default and TIMEOUT default constants.
REQ-031 One sub-module gbt_tx_frameclk_phalgnr_sync (2-flop synchronizer, parameterised reset value) SHALL be instantiated twice.

Verification
REQ-032 Reset, locked=1, start with target=10 -> 10 steps, updn=1, each phase_en 2 cycles wide, cur_phase=10, one done pulse, error=0.
REQ-033 From cur_phase=10, target=140 -> 14 down-steps, wrapping through 0 to 143, final cur_phase=140.
REQ-034 target=cur_phase -> done at N+2, phase_en never asserted; target=144 -> error=1, no phase_en.
REQ-035 PLL model holds phase_done high after phase_en -> error=1 at timeout+1 cycles, busy=0, cur_phase unchanged.
REQ-036 locked deasserted during WAIT_LO -> phase_en=0, cur_phase=0, error=1, IDLE; start during busy has no effect.
